dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Shares the CPU's 256x8 data memory between two requesters.
//   Port 0 is the core's load/store path; port 1 is the debug/loader port (UART monitor).
//   Round-robin arbitration with a req/gnt/rvalid handshake; owns the RAM array internally.
//   Sits between core and memory; the core stalls its execute phase until gnt0/rvalid0.
// PARAMETERS
//   AW  8  address width (depth = 2**AW words)
//   DW  8  data width
// PORTS
//   clk      in   1   system clock, all logic on rising edge
//   rst_n    in   1   reset, asynchronous assert, active-low
//   req0     in   1   port0 request; hold with payload stable until gnt0
//   we0      in   1   port0 1=write, 0=read
//   addr0    in   AW  port0 address
//   wdata0   in   DW  port0 write data
//   gnt0     out  1   port0 accepted/performed (1-cycle pulse)
//   rvalid0  out  1   port0 read data valid (1-cycle pulse)
//   rdata0   out  DW  port0 read data, valid only with rvalid0
//   req1/we1/addr1/wdata1/gnt1/rvalid1/rdata1   same as port0, for port1
//   busy     out  1   high whenever FSM is not in ARB
// BEHAVIOUR
//   Reset (rst_n=0, async): state=ARB, last=1 (port0 wins first), gnt*/rvalid*/busy=0,
//     rdata*=0. RAM contents NOT reset; an in-flight access is discarded, no gnt/rvalid.
//   FSM ARB: if no req, stay. Otherwise pick winner, latch we/addr/wdata/winner, go MEM.
//     - one req -> that port; both -> port != last; last <= winner.
//   FSM MEM: perform RAM access with latched payload; gnt[winner] <= 1 for one cycle
//     (registered, visible in the cycle after MEM). Write -> ARB; read -> RESP.
//   FSM RESP: rvalid[winner]=1 and rdata[winner]=RAM data, one cycle; -> ARB.
//   Latency (req high at edge N in ARB): gnt at N+2; read rvalid at N+3; next arbitration
//     at N+2 (write) / N+3 (read). Throughput: one write per 2, one read per 3 cycles.
//   Requester must drop req in the cycle gnt is seen, or it is re-arbitrated as a new access.
//   req dropped before gnt: protocol violation; latched transaction still completes.
//   Loser's req is held pending; at most one access by the other port before it wins (no starvation).
//   Only the winner's rdata is updated; the other rdata holds its last value.
//   addr is used as-is, full AW bits, no wrap/bounds logic; x on inputs of non-requesting port ignored.
//   Read-after-write same address, any port: read returns new data (write completes in MEM first).
// STRUCTURE
//   Shared package: state encoding (ARB/MEM/RESP), PORT_CPU=0 / PORT_DBG=1 constants,
//     default AW/DW.
//   Sub-module dmem_ram: single-port sync RAM, 1-cycle read, write-first, no reset on array.
//   Arbiter FSM, round-robin pointer and payload latch in this module.
// TESTING
//   Reset: hold rst_n=0 mid-stimulus -> gnt0/1, rvalid0/1, busy = 0 immediately, state ARB.
//   Port0 write addr 0x10 data 0xA5, then read 0x10 -> gnt0 at N+2, rvalid0 at N+3 with rdata0=0xA5.
//   req0 and req1 together from reset (read 0x01 / read 0x02) -> port0 served first, then port1.
//   Both held requesting 4 accesses each -> grants alternate 0,1,0,1..., no port served twice in a row.
//   Port1 alone, back-to-back writes 0x20..0x23 -> each gnt1 2 cycles apart, data readable by port0.
//   Assert rst_n=0 during RESP of a port1 read -> no rvalid1; after release, first request served normally.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter: FSM states,
// port identifiers, default geometry and the round-robin pick.
package dmem_arbiter_pkg;

    localparam int DEF_AW    = 8;
    localparam int DEF_DW    = 8;
    localparam int NUM_PORTS = 2;

    localparam bit PORT_CPU = 1'b0;
    localparam bit PORT_DBG = 1'b1;

    typedef enum logic [1:0] {
        ST_ARB  = 2'd0,
        ST_MEM  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Lone requester wins outright; on contention the port not served last wins.
    function automatic logic pick_winner(input logic [NUM_PORTS-1:0] req, input logic last);
        if (req == 2'b11) return ~last;
        return req[1];
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter: req/gnt/rvalid handshake.
interface dmem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
) ();
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter_ram.sv
// Single-port synchronous RAM, one-cycle read, write-first; array is never reset.
module dmem_ram #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
                rdata     <= wdata;
            end else begin
                rdata     <= mem[addr];
            end
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one 2**AW x DW data RAM between the core (port 0)
// and the debug/loader port (port 1). ARB -> MEM -> (RESP) per access.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  p0,
    dmem_arbiter_if.slave  p1,
    output logic           busy
);
    state_e                        state;
    logic                          last;
    logic                          win;
    logic                          lat_we;
    logic [AW-1:0]                 lat_addr;
    logic [DW-1:0]                 lat_wdata;
    logic [NUM_PORTS-1:0]          gnt_q;
    logic [NUM_PORTS-1:0]          rvalid_q;
    logic [NUM_PORTS-1:0][DW-1:0]  rdata_q;
    logic [DW-1:0]                 ram_q;

    logic [NUM_PORTS-1:0] req;
    logic                 nxt_win;
    logic                 sel_we;
    logic [AW-1:0]        sel_addr;
    logic [DW-1:0]        sel_wdata;

    assign req       = {p1.req, p0.req};
    assign nxt_win   = pick_winner(req, last);
    assign sel_we    = nxt_win ? p1.we    : p0.we;
    assign sel_addr  = nxt_win ? p1.addr  : p0.addr;
    assign sel_wdata = nxt_win ? p1.wdata : p0.wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_ARB;
            last      <= 1'b1;
            win       <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            gnt_q     <= '0;
            rvalid_q  <= '0;
            rdata_q   <= '0;
        end else begin
            gnt_q    <= '0;
            rvalid_q <= '0;
            case (state)
                ST_ARB: begin
                    if (|req) begin
                        win       <= nxt_win;
                        last      <= nxt_win;
                        lat_we    <= sel_we;
                        lat_addr  <= sel_addr;
                        lat_wdata <= sel_wdata;
                        state     <= ST_MEM;
                    end
                end
                ST_MEM: begin
                    gnt_q[win] <= 1'b1;
                    state      <= lat_we ? ST_ARB : ST_RESP;
                end
                ST_RESP: begin
                    // Only the winner's read-data register moves; the other holds.
                    rvalid_q[win] <= 1'b1;
                    rdata_q[win]  <= ram_q;
                    state         <= ST_ARB;
                end
                default: state <= ST_ARB;
            endcase
        end
    end

    dmem_ram #(.AW(AW), .DW(DW)) u_ram (
        .clk   (clk),
        .en    (state == ST_MEM),
        .we    (lat_we),
        .addr  (lat_addr),
        .wdata (lat_wdata),
        .rdata (ram_q)
    );

    assign p0.gnt    = gnt_q[PORT_CPU];
    assign p0.rvalid = rvalid_q[PORT_CPU];
    assign p0.rdata  = rdata_q[PORT_CPU];
    assign p1.gnt    = gnt_q[PORT_DBG];
    assign p1.rvalid = rvalid_q[PORT_DBG];
    assign p1.rdata  = rdata_q[PORT_DBG];
    assign busy      = (state != ST_ARB);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: per-port drivers, transaction-level memory
// model and a negedge monitor checking grant order, latency and read data.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(8), .DW(8)) if0 ();
    dmem_arbiter_if #(.AW(8), .DW(8)) if1 ();
    logic busy;

    dmem_arbiter #(.AW(8), .DW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .p0    (if0.slave),
        .p1    (if1.slave),
        .busy  (busy)
    );

    logic [1:0]       d_req = '0, d_we = '0;
    logic [1:0][7:0]  d_addr = '0, d_wdata = '0;
    logic [1:0]       o_gnt, o_rvalid;
    logic [1:0][7:0]  o_rdata;

    assign if0.req = d_req[0];   assign if1.req = d_req[1];
    assign if0.we = d_we[0];     assign if1.we = d_we[1];
    assign if0.addr = d_addr[0]; assign if1.addr = d_addr[1];
    assign if0.wdata = d_wdata[0]; assign if1.wdata = d_wdata[1];
    assign o_gnt    = {if1.gnt, if0.gnt};
    assign o_rvalid = {if1.rvalid, if0.rvalid};
    assign o_rdata  = {if1.rdata, if0.rdata};

    typedef struct { bit we; bit [7:0] addr; bit [7:0] wdata; int gap; } txn_t;
    typedef struct { bit we; bit [7:0] addr; bit [7:0] wdata; int issue; } iss_t;
    typedef struct { int cyc; bit known; bit [7:0] data; } rd_t;
    typedef struct { int port; bit we; int issue; int gcyc; } glog_t;

    txn_t  prog[2][$];
    iss_t  issued[2][$];
    rd_t   exp_rd[2][$];
    glog_t glog[$];
    bit [7:0] refmem[256];
    bit       known[256];
    logic [7:0] exp_rdata[2];
    int rvcnt[2];
    int waitcnt[2];
    int last_srv = 1;
    int cyc = 0;
    int n_tests = 0, n_fail = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic issue(input int p);
        txn_t t;
        t = prog[p].pop_front();
        d_req[p] = 1'b1; d_we[p] = t.we; d_addr[p] = t.addr; d_wdata[p] = t.wdata;
        issued[p].push_back('{t.we, t.addr, t.wdata, cyc});
    endtask

    // Drivers: hold payload until gnt; gap 0 keeps req up with the next access.
    initial begin
        waitcnt[0] = 0; waitcnt[1] = 0;
        forever begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (!rst_n) begin
                    d_req[p] = 1'b0; waitcnt[p] = 0;
                end else if (d_req[p] && o_gnt[p]) begin
                    if (prog[p].size() > 0 && prog[p][0].gap == 0) issue(p);
                    else begin
                        d_req[p] = 1'b0;
                        d_we[p] = 1'($urandom); d_addr[p] = 8'($urandom); d_wdata[p] = 8'($urandom);
                        waitcnt[p] = (prog[p].size() > 0) ? prog[p][0].gap - 1 : 0;
                    end
                end else if (!d_req[p]) begin
                    if (waitcnt[p] > 0) waitcnt[p]--;
                    else if (prog[p].size() > 0) issue(p);
                end
            end
        end
    end

    task automatic on_gnt(input int p);
        iss_t it;
        if (issued[p].size() == 0) begin
            chk("gnt_spurious", 1, 0);
            return;
        end
        it = issued[p][0];
        chk("gnt_latency_min", 32'((cyc - it.issue) >= 2), 1);
        // Both waiting at the arbitration edge: the port not served last must win.
        if (issued[1-p].size() > 0 && issued[1-p][0].issue <= cyc - 2)
            chk("rr_order", p, 1 - last_srv);
        last_srv = p;
        void'(issued[p].pop_front());
        chk("busy_at_gnt", busy, !it.we);
        if (it.we) begin
            refmem[it.addr] = it.wdata; known[it.addr] = 1'b1;
        end else begin
            exp_rd[p].push_back('{cyc + 1, known[it.addr], refmem[it.addr]});
        end
        glog.push_back('{p, it.we, it.issue, cyc});
    endtask

    // Monitor
    initial begin
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        rvcnt[0] = 0; rvcnt[1] = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_gnt", o_gnt, 0);
                chk("rst_rvalid", o_rvalid, 0);
                chk("rst_busy", busy, 0);
                for (int p = 0; p < 2; p++) begin
                    issued[p].delete(); exp_rd[p].delete(); exp_rdata[p] = '0;
                end
                last_srv = 1;
            end else begin
                if (|o_gnt) chk("gnt_onehot", 32'(o_gnt == 2'b11), 0);
                for (int p = 0; p < 2; p++) if (o_gnt[p]) on_gnt(p);
                for (int p = 0; p < 2; p++) begin
                    if (o_rvalid[p]) begin
                        if (exp_rd[p].size() == 0) chk("rvalid_spurious", 1, 0);
                        else begin
                            rd_t e;
                            e = exp_rd[p].pop_front();
                            chk("rvalid_cycle", cyc, e.cyc);
                            if (e.known) chk("rdata", o_rdata[p], e.data);
                        end
                        exp_rdata[p] = o_rdata[p];
                        rvcnt[p]++;
                    end else begin
                        if (exp_rd[p].size() > 0 && exp_rd[p][0].cyc < cyc) begin
                            chk("rvalid_missing", 0, 1);
                            void'(exp_rd[p].pop_front());
                        end
                        if (o_rvalid[1-p]) chk("rdata_hold", o_rdata[p], exp_rdata[p]);
                    end
                    if (issued[p].size() > 0 && cyc - issued[p][0].issue > 12) begin
                        chk("gnt_timeout", 0, 1);
                        void'(issued[p].pop_front());
                    end
                end
            end
        end
    end

    function automatic bit idle();
        return prog[0].size() == 0 && prog[1].size() == 0 && d_req == 2'b00 &&
               issued[0].size() == 0 && issued[1].size() == 0 &&
               exp_rd[0].size() == 0 && exp_rd[1].size() == 0;
    endfunction

    task automatic wait_idle(input int bound);
        int n = 0;
        @(negedge clk); #1;
        while (!idle() && n < bound) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= bound) chk("idle_timeout", 0, 1);
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        @(negedge clk); #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int base, n, s;
        bit seen;
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("reset_gnt", o_gnt, 0);
        chk("reset_rvalid", o_rvalid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_rdata", o_rdata, 0);
        #1 rst_n = 1'b1;

        // Port0 write 0x10=A5 then read it back
        glog.delete();
        prog[0].push_back('{1'b1, 8'h10, 8'hA5, 1});
        prog[0].push_back('{1'b0, 8'h10, 8'h00, 1});
        wait_idle(100);
        chk("t2_grants", glog.size(), 2);
        if (glog.size() == 2) begin
            chk("t2_wr_port", glog[0].port, 0);
            chk("t2_wr_latency", glog[0].gcyc - glog[0].issue, 2);
            chk("t2_rd_latency", glog[1].gcyc - glog[1].issue, 2);
        end
        chk("t2_rdata0", o_rdata[0], 8'hA5);

        // Simultaneous reads straight after reset: port0 first
        prog[1].push_back('{1'b1, 8'h01, 8'h11, 1});
        prog[0].push_back('{1'b1, 8'h02, 8'h22, 1});
        wait_idle(100);
        reset_pulse();
        glog.delete();
        prog[0].push_back('{1'b0, 8'h01, 8'h00, 1});
        prog[1].push_back('{1'b0, 8'h02, 8'h00, 1});
        wait_idle(100);
        chk("t3_grants", glog.size(), 2);
        if (glog.size() == 2) begin
            chk("t3_first", glog[0].port, 0);
            chk("t3_second", glog[1].port, 1);
        end
        chk("t3_rdata0", o_rdata[0], 8'h11);
        chk("t3_rdata1", o_rdata[1], 8'h22);

        // Both held for 4 accesses each: strict alternation
        glog.delete();
        for (int i = 0; i < 4; i++)
            for (int p = 0; p < 2; p++)
                prog[p].push_back('{1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom), 0});
        wait_idle(200);
        chk("t4_grants", glog.size(), 8);
        for (int i = 1; i < glog.size(); i++)
            chk("t4_alternate", 32'(glog[i].port != glog[i-1].port), 1);

        // Port1 back-to-back writes 0x20..0x23, then port0 reads them
        glog.delete();
        for (int i = 0; i < 4; i++) prog[1].push_back('{1'b1, 8'(8'h20 + i), 8'(8'h30 + i), 0});
        wait_idle(100);
        chk("t5_grants", glog.size(), 4);
        for (int i = 1; i < glog.size(); i++) chk("t5_spacing", glog[i].gcyc - glog[i-1].gcyc, 2);
        for (int i = 0; i < 4; i++) prog[0].push_back('{1'b0, 8'(8'h20 + i), 8'h00, 1});
        wait_idle(100);
        chk("t5_rdata0", o_rdata[0], 8'h33);

        // Reset during RESP of a port1 read
        prog[1].push_back('{1'b0, 8'h20, 8'h00, 0});
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = o_gnt[1];
        end
        chk("t6_gnt1_seen", seen, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_gnt1_cleared", o_gnt[1], 0);
        chk("t6_busy_cleared", busy, 0);
        chk("t6_rvalid1", o_rvalid[1], 0);
        base = rvcnt[1];
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("t6_no_rvalid1", rvcnt[1], base);
        glog.delete();
        prog[1].push_back('{1'b0, 8'h21, 8'h00, 1});
        wait_idle(100);
        chk("t6_after_grants", glog.size(), 1);
        if (glog.size() == 1) chk("t6_after_latency", glog[0].gcyc - glog[0].issue, 2);
        chk("t6_rdata1", o_rdata[1], 8'h31);

        // Random traffic against the reference model
        n = 150;
        for (int i = 0; i < n; i++)
            for (int p = 0; p < 2; p++) begin
                s = $urandom_range(0, 3);
                prog[p].push_back('{1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom), s});
            end
        wait_idle(5000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
